// File: rtl/counter_n_if.sv
// counter_n_if: control and status bundle between a counter_n and its user
interface counter_n_if #(
    parameter int WIDTH = 3
);
    logic             en;
    logic             up_dn;
    logic             clr;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] cnt;
    logic             tc;
    logic             wrap;
    logic             sat;

    modport master (
        output en, up_dn, clr, load, load_val,
        input  cnt, tc, wrap, sat
    );

    modport slave (
        input  en, up_dn, clr, load, load_val,
        output cnt, tc, wrap, sat
    );
endinterface

// File: rtl/counter_n.sv
// counter_n: up/down modulo counter with clear, clamped load, terminal count and wrap/saturate
module counter_n #(
    parameter int WIDTH    = 3,
    parameter int MODULUS  = 8,
    parameter int SATURATE = 0
) (
    input  logic        clk,
    input  logic        rst,
    counter_n_if.slave  bus_if
);
    // MAX_X is held one bit wider so MODULUS = 2^WIDTH still compares correctly
    localparam logic [WIDTH:0]   MAX_X = (WIDTH+1)'(MODULUS - 1);
    localparam logic [WIDTH-1:0] MAX_W = MAX_X[WIDTH-1:0];
    localparam logic             SAT   = (SATURATE != 0);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             wrap_q, wrap_d;
    logic             sat_q, sat_d;
    logic             at_top, at_bot, hit, over;

    // next-state: clr beats load beats en; an enabled count at an end wraps or holds
    always_comb begin
        at_top = {1'b0, cnt_q} == MAX_X;
        at_bot = cnt_q == '0;
        over   = {1'b0, bus_if.load_val} > MAX_X;
        hit    = bus_if.en & ~bus_if.clr & ~bus_if.load & (bus_if.up_dn ? at_top : at_bot);
        cnt_d  = bus_if.clr   ? '0 :
                 bus_if.load  ? (over ? MAX_W : bus_if.load_val) :
                 !bus_if.en   ? cnt_q :
                 hit          ? (SAT ? cnt_q : (bus_if.up_dn ? '0 : MAX_W)) :
                 bus_if.up_dn ? cnt_q + 1'b1 : cnt_q - 1'b1;
        wrap_d = hit & ~SAT;
        sat_d  = hit & SAT;
    end

    // state register with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            wrap_q <= 1'b0;
            sat_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
            sat_q  <= sat_d;
        end
    end

    assign bus_if.cnt  = cnt_q;
    assign bus_if.tc   = hit;
    assign bus_if.wrap = wrap_q;
    assign bus_if.sat  = sat_q;
endmodule

// File: tb/tb_counter_n.sv
// tb_counter_n: scoreboard bench covering wrap, down count, saturate, priority, async reset, cascade
module tb_counter_n;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int   cnt;
        logic wrap;
        logic sat;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    counter_n_if #(.WIDTH(3)) if_a ();
    counter_n_if #(.WIDTH(3)) if_b ();
    counter_n_if #(.WIDTH(3)) if_c ();
    counter_n_if #(.WIDTH(4)) if_lo ();
    counter_n_if #(.WIDTH(4)) if_hi ();

    counter_n #(.WIDTH(3), .MODULUS(8),  .SATURATE(0)) dut_a  (.clk(clk), .rst(rst), .bus_if(if_a.slave));
    counter_n #(.WIDTH(3), .MODULUS(6),  .SATURATE(0)) dut_b  (.clk(clk), .rst(rst), .bus_if(if_b.slave));
    counter_n #(.WIDTH(3), .MODULUS(6),  .SATURATE(1)) dut_c  (.clk(clk), .rst(rst), .bus_if(if_c.slave));
    counter_n #(.WIDTH(4), .MODULUS(16), .SATURATE(0)) dut_lo (.clk(clk), .rst(rst), .bus_if(if_lo.slave));
    counter_n #(.WIDTH(4), .MODULUS(16), .SATURATE(0)) dut_hi (.clk(clk), .rst(rst), .bus_if(if_hi.slave));

    assign if_hi.en = if_lo.tc;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        {if_a.en, if_a.up_dn, if_a.clr, if_a.load, if_a.load_val} = '0;
        {if_b.en, if_b.up_dn, if_b.clr, if_b.load, if_b.load_val} = '0;
        {if_c.en, if_c.up_dn, if_c.clr, if_c.load, if_c.load_val} = '0;
        {if_lo.en, if_lo.up_dn, if_lo.clr, if_lo.load, if_lo.load_val} = '0;
        {if_hi.up_dn, if_hi.clr, if_hi.load, if_hi.load_val} = '0;
        tick();
        tick();
        checks++;
        if ({if_a.cnt, if_a.wrap, if_a.sat} !== 5'b0) begin
            errors++;
            $display("FAIL reset_a cnt/wrap/sat: got %0d/%b/%b expected 0/0/0", if_a.cnt, if_a.wrap, if_a.sat);
        end
        checks++;
        if ({if_c.cnt, if_c.wrap, if_c.sat} !== 5'b0) begin
            errors++;
            $display("FAIL reset_c cnt/wrap/sat: got %0d/%b/%b expected 0/0/0", if_c.cnt, if_c.wrap, if_c.sat);
        end
        checks++;
        if (if_a.tc !== 1'b0) begin
            errors++;
            $display("FAIL reset_tc: got %b expected 0", if_a.tc);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_free_run();
        int seq[10] = '{1, 2, 3, 4, 5, 6, 7, 0, 1, 2};
        int prev = 0;
        exp_t e;
        if_a.en = 1'b1;
        if_a.up_dn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            checks++;
            if (if_a.tc !== (prev == 7)) begin
                errors++;
                $display("FAIL free_run tc at cnt %0d: got %b expected %b", prev, if_a.tc, prev == 7);
            end
            sb.push_back('{seq[i], seq[i] == 0, 1'b0});
            tick();
            e = sb.pop_front();
            checks++;
            if (int'(if_a.cnt) !== e.cnt || if_a.wrap !== e.wrap || if_a.sat !== e.sat) begin
                errors++;
                $display("FAIL free_run step %0d cnt/wrap/sat: got %0d/%b/%b expected %0d/%b/%b",
                         i, if_a.cnt, if_a.wrap, if_a.sat, e.cnt, e.wrap, e.sat);
            end
            prev = seq[i];
        end
        if_a.en = 1'b0;
    endtask

    task automatic test_down();
        int seq[4] = '{1, 0, 5, 4};
        int prev = 2;
        exp_t e;
        if_b.load = 1'b1;
        if_b.load_val = 3'd2;
        sb.push_back('{2, 1'b0, 1'b0});
        tick();
        e = sb.pop_front();
        checks++;
        if (int'(if_b.cnt) !== e.cnt) begin
            errors++;
            $display("FAIL down load cnt: got %0d expected %0d", if_b.cnt, e.cnt);
        end
        if_b.load = 1'b0;
        if_b.en = 1'b1;
        if_b.up_dn = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (if_b.tc !== (prev == 0)) begin
                errors++;
                $display("FAIL down tc at cnt %0d: got %b expected %b", prev, if_b.tc, prev == 0);
            end
            sb.push_back('{seq[i], seq[i] == 5, 1'b0});
            tick();
            e = sb.pop_front();
            checks++;
            if (int'(if_b.cnt) !== e.cnt || if_b.wrap !== e.wrap || if_b.sat !== e.sat) begin
                errors++;
                $display("FAIL down step %0d cnt/wrap/sat: got %0d/%b/%b expected %0d/%b/%b",
                         i, if_b.cnt, if_b.wrap, if_b.sat, e.cnt, e.wrap, e.sat);
            end
            prev = seq[i];
        end
        if_b.en = 1'b0;
    endtask

    task automatic test_saturate();
        int prev = 4;
        exp_t e;
        if_c.load = 1'b1;
        if_c.load_val = 3'd4;
        sb.push_back('{4, 1'b0, 1'b0});
        tick();
        e = sb.pop_front();
        checks++;
        if (int'(if_c.cnt) !== e.cnt) begin
            errors++;
            $display("FAIL saturate load cnt: got %0d expected %0d", if_c.cnt, e.cnt);
        end
        if_c.load = 1'b0;
        if_c.en = 1'b1;
        if_c.up_dn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (if_c.tc !== (prev == 5)) begin
                errors++;
                $display("FAIL saturate tc at cnt %0d: got %b expected %b", prev, if_c.tc, prev == 5);
            end
            sb.push_back('{5, 1'b0, i > 0});
            tick();
            e = sb.pop_front();
            checks++;
            if (int'(if_c.cnt) !== e.cnt || if_c.wrap !== e.wrap || if_c.sat !== e.sat) begin
                errors++;
                $display("FAIL saturate step %0d cnt/wrap/sat: got %0d/%b/%b expected %0d/%b/%b",
                         i, if_c.cnt, if_c.wrap, if_c.sat, e.cnt, e.wrap, e.sat);
            end
            prev = 5;
        end
        if_c.up_dn = 1'b0;
        sb.push_back('{4, 1'b0, 1'b0});
        tick();
        e = sb.pop_front();
        checks++;
        if (int'(if_c.cnt) !== e.cnt || if_c.sat !== e.sat || if_c.wrap !== e.wrap) begin
            errors++;
            $display("FAIL saturate reverse cnt/wrap/sat: got %0d/%b/%b expected %0d/%b/%b",
                     if_c.cnt, if_c.wrap, if_c.sat, e.cnt, e.wrap, e.sat);
        end
        if_c.en = 1'b0;
    endtask

    task automatic test_priority();
        exp_t e;
        if_a.load = 1'b1;
        if_a.load_val = 3'd3;
        sb.push_back('{3, 1'b0, 1'b0});
        tick();
        e = sb.pop_front();
        checks++;
        if (int'(if_a.cnt) !== e.cnt) begin
            errors++;
            $display("FAIL prio setup cnt: got %0d expected %0d", if_a.cnt, e.cnt);
        end
        {if_a.clr, if_a.load, if_a.en, if_a.up_dn, if_a.load_val} = {1'b1, 1'b1, 1'b1, 1'b1, 3'd5};
        sb.push_back('{0, 1'b0, 1'b0});
        tick();
        e = sb.pop_front();
        checks++;
        if (int'(if_a.cnt) !== e.cnt) begin
            errors++;
            $display("FAIL prio clr_over_load cnt: got %0d expected %0d", if_a.cnt, e.cnt);
        end
        {if_a.clr, if_a.load_val} = {1'b0, 3'd6};
        sb.push_back('{6, 1'b0, 1'b0});
        tick();
        e = sb.pop_front();
        checks++;
        if (int'(if_a.cnt) !== e.cnt) begin
            errors++;
            $display("FAIL prio load_over_en cnt: got %0d expected %0d", if_a.cnt, e.cnt);
        end
        if_a.load_val = 3'd7;
        sb.push_back('{7, 1'b0, 1'b0});
        tick();
        e = sb.pop_front();
        checks++;
        if (int'(if_a.cnt) !== e.cnt) begin
            errors++;
            $display("FAIL prio load_full_range cnt: got %0d expected %0d", if_a.cnt, e.cnt);
        end
        checks++;
        if (if_a.tc !== 1'b0) begin
            errors++;
            $display("FAIL prio tc_masked_by_load: got %b expected 0", if_a.tc);
        end
        if_a.load = 1'b0;
        #1;
        checks++;
        if (if_a.tc !== 1'b1) begin
            errors++;
            $display("FAIL prio tc_at_top: got %b expected 1", if_a.tc);
        end
        sb.push_back('{0, 1'b1, 1'b0});
        tick();
        e = sb.pop_front();
        checks++;
        if (int'(if_a.cnt) !== e.cnt || if_a.wrap !== e.wrap) begin
            errors++;
            $display("FAIL prio wrap_full_range cnt/wrap: got %0d/%b expected %0d/%b", if_a.cnt, if_a.wrap, e.cnt, e.wrap);
        end
        {if_a.clr, if_a.up_dn} = {1'b1, 1'b0};
        #1;
        checks++;
        if (if_a.tc !== 1'b0) begin
            errors++;
            $display("FAIL prio tc_masked_by_clr: got %b expected 0", if_a.tc);
        end
        sb.push_back('{0, 1'b0, 1'b0});
        tick();
        e = sb.pop_front();
        checks++;
        if (int'(if_a.cnt) !== e.cnt || if_a.wrap !== e.wrap) begin
            errors++;
            $display("FAIL prio clr_no_wrap cnt/wrap: got %0d/%b expected %0d/%b", if_a.cnt, if_a.wrap, e.cnt, e.wrap);
        end
        {if_a.clr, if_a.en} = 2'b00;
        sb.push_back('{0, 1'b0, 1'b0});
        tick();
        e = sb.pop_front();
        checks++;
        if (int'(if_a.cnt) !== e.cnt || if_a.wrap !== e.wrap) begin
            errors++;
            $display("FAIL prio hold cnt/wrap: got %0d/%b expected %0d/%b", if_a.cnt, if_a.wrap, e.cnt, e.wrap);
        end
        {if_b.load, if_b.load_val} = {1'b1, 3'd7};
        sb.push_back('{5, 1'b0, 1'b0});
        tick();
        e = sb.pop_front();
        checks++;
        if (int'(if_b.cnt) !== e.cnt) begin
            errors++;
            $display("FAIL prio clamp cnt: got %0d expected %0d", if_b.cnt, e.cnt);
        end
        if_b.load = 1'b0;
    endtask

    task automatic test_async_reset();
        exp_t e;
        {if_a.load, if_a.load_val} = {1'b1, 3'd5};
        {if_c.load, if_c.load_val, if_c.up_dn} = {1'b1, 3'd0, 1'b0};
        sb.push_back('{5, 1'b0, 1'b0});
        tick();
        e = sb.pop_front();
        checks++;
        if (int'(if_a.cnt) !== e.cnt) begin
            errors++;
            $display("FAIL areset setup cnt: got %0d expected %0d", if_a.cnt, e.cnt);
        end
        {if_a.load, if_c.load, if_c.en} = 3'b001;
        sb.push_back('{0, 1'b0, 1'b1});
        tick();
        e = sb.pop_front();
        checks++;
        if (int'(if_c.cnt) !== e.cnt || if_c.sat !== e.sat) begin
            errors++;
            $display("FAIL areset sat_low_end cnt/sat: got %0d/%b expected %0d/%b", if_c.cnt, if_c.sat, e.cnt, e.sat);
        end
        {if_a.en, if_a.up_dn} = 2'b11;
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({if_a.cnt, if_a.wrap, if_a.sat} !== 5'b0) begin
            errors++;
            $display("FAIL areset a_cleared cnt/wrap/sat: got %0d/%b/%b expected 0/0/0", if_a.cnt, if_a.wrap, if_a.sat);
        end
        checks++;
        if ({if_c.cnt, if_c.sat} !== 4'b0) begin
            errors++;
            $display("FAIL areset c_cleared cnt/sat: got %0d/%b expected 0/0", if_c.cnt, if_c.sat);
        end
        tick();
        checks++;
        if (if_a.cnt !== 3'd0 || if_c.sat !== 1'b0) begin
            errors++;
            $display("FAIL areset held cnt/sat: got %0d/%b expected 0/0", if_a.cnt, if_c.sat);
        end
        #2;
        rst = 1'b1;
        if_c.en = 1'b0;
        sb.push_back('{1, 1'b0, 1'b0});
        tick();
        e = sb.pop_front();
        checks++;
        if (int'(if_a.cnt) !== e.cnt) begin
            errors++;
            $display("FAIL areset resume cnt: got %0d expected %0d", if_a.cnt, e.cnt);
        end
        if_a.en = 1'b0;
    endtask

    task automatic test_cascade();
        exp_t e_lo, e_hi;
        int pulses = 0;
        int n = 300;
        {if_lo.en, if_lo.up_dn, if_hi.up_dn} = 3'b111;
        sb.push_back('{n % 16, 1'b0, 1'b0});
        sb.push_back('{(n / 16) % 16, 1'b0, 1'b0});
        for (int i = 0; i < n; i++) begin
            #1;
            if (if_lo.tc) pulses++;
            tick();
        end
        if_lo.en = 1'b0;
        e_lo = sb.pop_front();
        e_hi = sb.pop_front();
        checks++;
        if (int'(if_lo.cnt) !== e_lo.cnt) begin
            errors++;
            $display("FAIL cascade low cnt: got %0d expected %0d", if_lo.cnt, e_lo.cnt);
        end
        checks++;
        if (int'(if_hi.cnt) !== e_hi.cnt) begin
            errors++;
            $display("FAIL cascade high cnt: got %0d expected %0d", if_hi.cnt, e_hi.cnt);
        end
        checks++;
        if (pulses !== n / 16) begin
            errors++;
            $display("FAIL cascade tc pulses: got %0d expected %0d", pulses, n / 16);
        end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_down();
        test_saturate();
        test_priority();
        test_async_reset();
        test_cascade();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/counter_n.md
# counter_n

Parametrised synchronous binary counter, the general-purpose successor to the fixed 3-bit up counter. It counts up or down modulo a programmable modulus, with enable, synchronous clear, parallel load, a terminal-count flag and a wrap-or-saturate mode. It feeds sequencing and timing logic that needs a counter of arbitrary length and direction from one shared block.

## Interface

**Parameters**
- `WIDTH`, default 3: counter width in bits; legal range 1..16.
- `MODULUS`, default 8: count range is 0..MODULUS-1; legal range 2..2^WIDTH.
- `SATURATE`, default 0: selects the end-of-range behaviour.
  - 0: wrap at the ends of the range.
  - 1: hold at the ends of the range.

**Ports**
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `en` in 1: count enable.
- `up_dn` in 1: direction; 1 counts up, 0 counts down.
- `clr` in 1: synchronous clear to 0.
- `load` in 1: synchronous parallel load.
- `load_val` in WIDTH: value to load.
- `cnt` out WIDTH: current count (registered).
- `tc` out 1: terminal count (combinational).
- `wrap` out 1: one-cycle pulse after a wrap (registered).
- `sat` out 1: level, high while the counter is held at an end (registered).

## Operation

- **Reset:** `rst`=0 asynchronously forces `cnt`=0, `wrap`=0, `sat`=0. Outputs stay there while `rst` is low. Deassertion is synchronised externally; the first update is on the first rising edge with `rst`=1.
- **Priority per edge:** `clr` > `load` > `en`. With none asserted, `cnt` holds.
- **clr:** `cnt`←0.
- **load:** `cnt`←`load_val`.
  - If `load_val` ≥ MODULUS, load MODULUS-1 (clamp).
  - `load` ignores `en` and `up_dn`.
- **en, up:**
  - If `cnt` < MODULUS-1: `cnt`←`cnt`+1.
  - At MODULUS-1, SATURATE=0: `cnt`←0.
  - At MODULUS-1, SATURATE=1: `cnt` holds.
- **en, down:**
  - If `cnt` > 0: `cnt`←`cnt`-1.
  - At 0, SATURATE=0: `cnt`←MODULUS-1.
  - At 0, SATURATE=1: `cnt` holds.
- **Arithmetic:** compare and increment at WIDTH+1 bits internally. No intermediate value may exceed MODULUS-1, including when MODULUS=2^WIDTH.
- **tc:** `tc` = `en` & ~`clr` & ~`load` & (`up_dn` ? `cnt`==MODULUS-1 : `cnt`==0).
- **wrap:** registered. Set to 1 on an edge where a wrap occurred (SATURATE=0 only); cleared on every other edge. It is always 0 when SATURATE=1.
- **sat:** registered. Set to 1 on an edge where an enabled count was blocked at an end (SATURATE=1 only); cleared on any other edge, including clr, load, a count away from the end, or `en`=0. It is always 0 when SATURATE=0.
- **Direction change:** may change on any cycle; no pipeline, it takes effect on the same edge.
- **Mid-operation reset:** any cycle; all state returns to the reset values immediately.

## Timing

- Latency from `en`/`clr`/`load` sampled to the new `cnt`: 1 clock.
- `tc` is valid in the same cycle as the inputs. It is intended for cascading into the `en` of a higher-order counter_n.
- `wrap` and `sat` are high in the cycle after the edge that wrapped or blocked, aligned with the new `cnt`.
- With `en` held high, SATURATE=0 and a constant direction, `wrap` pulses once every MODULUS cycles.
- No multicycle paths. `tc` is the only combinational input-to-output path.

## Test plan

- **Free-run up (defaults 3/8/0):** release `rst`, `en`=1, `up_dn`=1 for 10 cycles.
  - `cnt` = 1,2,…,7,0,1,2.
  - `tc` high while `cnt`=7.
  - `wrap` high only in the cycle `cnt`=0.
- **Down count, MODULUS=6:** load 2, then `en`=1, `up_dn`=0 for 4 cycles.
  - `cnt` = 2,1,0,5,4.
  - `tc` high at `cnt`=0.
  - `wrap` high in the cycle `cnt`=5.
- **Saturate, MODULUS=6, SATURATE=1:** load 4, `up_dn`=1, `en`=1 for 4 cycles.
  - `cnt` = 5,5,5,5.
  - `sat` 0 in the first cycle, 1 thereafter.
  - `wrap` always 0.
  - Then `up_dn`=0: `cnt`=4 and `sat`=0.
- **Priority and clamp, defaults 3/8/0:** `cnt`=3 with `clr`=1, `load`=1, `en`=1 → `cnt`=0.
  - Next cycle `load`=1, `load_val`=6, `en`=1 → `cnt`=6.
  - With MODULUS=6, `load_val`=7 → `cnt`=5.
- **Async reset mid-count:** at `cnt`=5, pull `rst` low between edges.
  - `cnt`, `wrap`, `sat` = 0 before the next edge.
  - After release, counting resumes from 0→1.
- **Cascade, two WIDTH=4 instances:** the low instance's `tc` drives the high instance's `en`; count up 300 cycles.
  - Combined value = 300 mod 256 = 44: high=2, low=12.
